// File: rtl/bnn_image_loader.sv
// Streams thresholded pixel rows into the shared input SRAM for the binary conv engine:
// one header word and dim row words per image, then the terminator word, then a conv_run pulse.
module bnn_image_loader #(
   parameter int unsigned THRESH_W = 8
) (
   input  logic                clk,
   input  logic                reset_b,
   input  logic                loader_run,
   input  logic [THRESH_W-1:0] threshold,
   output logic                loader_busy,
   input  logic                pix_valid,
   output logic                pix_ready,
   input  logic [THRESH_W-1:0] pix_data,
   input  logic                pix_last,
   output logic                sram_write_enable,
   output logic [11:0]         sram_write_address,
   output logic [15:0]         sram_write_data,
   input  logic                conv_busy,
   output logic                conv_run
);

   typedef enum logic [2:0] {IDLE, HDR, PIX, TERM, DONE} state_t;

   state_t              state, next_state;
   logic [THRESH_W-1:0] thr;
   logic [11:0]         ptr;
   logic [4:0]          dim;
   logic [4:0]          dim_dec;
   logic [3:0]          col, row;
   logic [15:0]         acc, row_word;
   logic                term_sent;
   logic                start, accept, row_end, img_end, pix_bit;

   always_comb begin
      start    = (state == IDLE) && loader_run && !conv_busy;
      accept   = pix_valid && pix_ready;
      row_end  = ({1'b0, col} == (dim - 5'd1));
      img_end  = row_end && ({1'b0, row} == (dim - 5'd1));
      pix_bit  = (pix_data >= thr);
      row_word = acc | (16'(pix_bit) << col);
      if (pix_data[4])      dim_dec = 5'd16;
      else if (pix_data[2]) dim_dec = 5'd12;
      else                  dim_dec = 5'd10;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = HDR;
         HDR:  if (accept) next_state = PIX;
         PIX:  if (accept && img_end) next_state = pix_last ? TERM : HDR;
         TERM: if (term_sent) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      pix_ready   = (state == HDR) || (state == PIX);
      loader_busy = (state == HDR) || (state == PIX) || (state == TERM);
      conv_run    = (state == DONE);
   end

   // Every SRAM write is registered one cycle after its trigger, so pixel intake never stalls.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         thr                <= '0;
         ptr                <= '0;
         dim                <= '0;
         col                <= '0;
         row                <= '0;
         acc                <= '0;
         term_sent          <= 1'b0;
         sram_write_enable  <= 1'b0;
         sram_write_address <= '0;
         sram_write_data    <= '0;
      end else begin
         sram_write_enable <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  thr       <= threshold;
                  ptr       <= '0;
                  term_sent <= 1'b0;
               end
            end
            HDR: begin
               if (accept) begin
                  dim                <= dim_dec;
                  sram_write_enable  <= 1'b1;
                  sram_write_address <= ptr;
                  sram_write_data    <= {11'd0, dim_dec};
                  ptr                <= ptr + 12'd1;
                  col                <= '0;
                  row                <= '0;
                  acc                <= '0;
               end
            end
            PIX: begin
               if (accept) begin
                  if (row_end) begin
                     sram_write_enable  <= 1'b1;
                     sram_write_address <= ptr;
                     sram_write_data    <= row_word;
                     ptr                <= ptr + 12'd1;
                     acc                <= '0;
                     col                <= '0;
                     row                <= row + 4'd1;
                  end else begin
                     acc <= row_word;
                     col <= col + 4'd1;
                  end
               end
            end
            TERM: begin
               // The final row write is on the bus during the first TERM cycle.
               if (sram_write_enable && !term_sent) begin
                  sram_write_enable  <= 1'b1;
                  sram_write_address <= ptr;
                  sram_write_data    <= 16'h00FF;
                  ptr                <= ptr + 12'd1;
                  term_sent          <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_image_loader.sv
// Randomized scoreboard bench for bnn_image_loader: an image-level model predicts SRAM words
// and the conv_run pulse; a negedge monitor pops and compares whatever the DUT emits.
module tb_bnn_image_loader;

   logic        clk = 1'b0;
   logic        reset_b, loader_run, pix_valid, pix_last, conv_busy;
   logic [7:0]  threshold, pix_data;
   logic        loader_busy, pix_ready, sram_write_enable, conv_run;
   logic [11:0] sram_write_address;
   logic [15:0] sram_write_data;

   bnn_image_loader #(.THRESH_W(8)) dut (
      .clk(clk), .reset_b(reset_b), .loader_run(loader_run), .threshold(threshold),
      .loader_busy(loader_busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_last(pix_last), .sram_write_enable(sram_write_enable),
      .sram_write_address(sram_write_address), .sram_write_data(sram_write_data),
      .conv_busy(conv_busy), .conv_run(conv_run)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_run;
      logic        is_term;
      logic [11:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       model_q[$];
   logic [7:0] s_data[$];
   bit         s_last[$];
   int         checks = 0;
   int         passed = 0;
   int         runs_seen = 0;
   logic [7:0] thr_m;
   int         ptr_m;
   bit         rand_last;
   bit         prev_term = 1'b0;

   function automatic exp_t mk(input bit r, input bit t, input int a, input int d);
      exp_t e;
      e.is_run  = r;
      e.is_term = t;
      e.addr    = 12'(a);
      e.data    = 16'(d);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
   endtask

   function automatic int dim_of(input logic [7:0] b);
      if (b[4]) return 16;
      if (b[2]) return 12;
      return 10;
   endfunction

   function automatic logic [7:0] mk_dimb(input int d);
      logic [7:0] b;
      b = 8'($urandom);
      if (d == 16) b[4] = 1'b1;
      else if (d == 12) begin b[4] = 1'b0; b[2] = 1'b1; end
      else begin b[4] = 1'b0; b[2] = 1'b0; end
      return b;
   endfunction

   // kind: 0 all 0xFF, 1 checkerboard, 2 random, 3 threshold-edge pattern
   function automatic logic [7:0] pixel(input int kind, input int r, input int c);
      case (kind)
         0: return 8'hFF;
         1: return ((r + c) % 2 == 1) ? 8'hFF : 8'h00;
         2: return 8'($urandom);
         default: return (r == 0 && c < 3) ? 8'(8'h3F + c) : 8'h00;
      endcase
   endfunction

   task automatic new_stream(input logic [7:0] thr);
      thr_m = thr;
      ptr_m = 0;
      model_q.delete();
      s_data.delete();
      s_last.delete();
   endtask

   task automatic add_image(input logic [7:0] dimb, input int kind);
      int d;
      int word;
      logic [7:0] p;
      d = dim_of(dimb);
      model_q.push_back(mk(0, 0, ptr_m % 4096, d));
      ptr_m++;
      s_data.push_back(dimb);
      s_last.push_back(1'b0);
      for (int r = 0; r < d; r++) begin
         word = 0;
         for (int c = 0; c < d; c++) begin
            p = pixel(kind, r, c);
            s_data.push_back(p);
            s_last.push_back(rand_last && ($urandom_range(7) == 0));
            if (p >= thr_m) word += (1 << c);
         end
         model_q.push_back(mk(0, 0, ptr_m % 4096, word));
         ptr_m++;
      end
   endtask

   // max_words < 0: full stream with terminator; otherwise only the first max_words words
   task automatic run_stream(input int max_words, input int abort_after, input int bubble_pct);
      int  r0;
      int  t;
      int  w;
      bit  acc;
      bit  stuck;
      if (abort_after == 0) begin
         s_last[s_last.size()-1] = 1'b1;
         model_q.push_back(mk(0, 1, ptr_m % 4096, 16'h00FF));
         model_q.push_back(mk(1, 0, 0, 0));
      end
      for (int i = 0; i < model_q.size(); i++)
         if (max_words < 0 || i < max_words) exp_q.push_back(model_q[i]);
      r0 = runs_seen;
      @(posedge clk); #1;
      loader_run = 1'b1;
      threshold  = thr_m;
      @(posedge clk); #1;
      loader_run = 1'b0;
      threshold  = 8'($urandom);
      check("busy_after_run", {31'd0, loader_busy}, 32'd1);
      stuck = 1'b0;
      for (int i = 0; i < s_data.size(); i++) begin
         if (abort_after > 0 && i == abort_after) break;
         while ($urandom_range(99) < bubble_pct) begin
            pix_valid = 1'b0;
            pix_data  = 8'($urandom);
            pix_last  = 1'($urandom);
            @(posedge clk); #1;
         end
         pix_valid = 1'b1;
         pix_data  = s_data[i];
         pix_last  = s_last[i];
         w = 0;
         do begin
            acc = pix_ready;
            @(posedge clk); #1;
            w++;
         end while (!acc && w < 50);
         if (!acc) begin
            checks++;
            $display("FAIL byte_accept_timeout: byte %0d not accepted, expected accept within 50 cycles", i);
            stuck = 1'b1;
            break;
         end
      end
      pix_valid = 1'b0;
      pix_last  = 1'b0;
      if (abort_after > 0) begin
         reset_b = 1'b0;
         #1;
         check("abort_busy",  {31'd0, loader_busy}, 32'd0);
         check("abort_ready", {31'd0, pix_ready}, 32'd0);
         check("abort_we",    {31'd0, sram_write_enable}, 32'd0);
         check("abort_addr",  {20'd0, sram_write_address}, 32'd0);
         check("abort_data",  {16'd0, sram_write_data}, 32'd0);
         check("abort_run",   {31'd0, conv_run}, 32'd0);
         check("abort_pending_words", exp_q.size(), 32'd0);
         exp_q.delete();
         repeat (3) @(posedge clk);
         #1 reset_b = 1'b1;
         repeat (20) @(posedge clk);
         #1;
         check("abort_no_conv_run", runs_seen - r0, 32'd0);
      end else begin
         t = 0;
         while (runs_seen == r0 && t < 200 && !stuck) begin
            @(posedge clk);
            t++;
         end
         check("conv_run_seen", runs_seen - r0, 32'd1);
         check("queue_drained", exp_q.size(), 32'd0);
         exp_q.delete();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   cur_term;
      cur_term = 1'b0;
      if (reset_b) begin
         if (pix_ready && !loader_busy) begin
            checks++;
            $display("FAIL ready_while_idle: pix_ready=1 loader_busy=0, expected pix_ready=0");
         end
         if (sram_write_enable) begin
            if (exp_q.size() == 0 || exp_q[0].is_run) begin
               checks++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                        sram_write_address, sram_write_data);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", {20'd0, sram_write_address}, {20'd0, e.addr});
               check("write_data", {16'd0, sram_write_data}, {16'd0, e.data});
               cur_term = e.is_term;
            end
         end
         if (conv_run) begin
            runs_seen++;
            if (exp_q.size() == 0 || !exp_q[0].is_run) begin
               checks++;
               $display("FAIL unexpected_conv_run: got conv_run=1, expected 0");
            end else begin
               void'(exp_q.pop_front());
               check("run_after_term", {31'd0, prev_term}, 32'd1);
               check("busy_low_at_run", {31'd0, loader_busy}, 32'd0);
               check("ready_low_at_run", {31'd0, pix_ready}, 32'd0);
            end
         end
      end
      prev_term = cur_term;
   end

   initial begin
      reset_b = 1'b0; loader_run = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
      conv_busy = 1'b0; threshold = '0; pix_data = '0; rand_last = 1'b0;
      #1;
      check("rst_busy",  {31'd0, loader_busy}, 32'd0);
      check("rst_ready", {31'd0, pix_ready}, 32'd0);
      check("rst_we",    {31'd0, sram_write_enable}, 32'd0);
      check("rst_addr",  {20'd0, sram_write_address}, 32'd0);
      check("rst_data",  {16'd0, sram_write_data}, 32'd0);
      check("rst_run",   {31'd0, conv_run}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_b = 1'b1;

      // single 10x10, all 0xFF
      new_stream(8'h80);
      add_image(mk_dimb(10), 0);
      run_stream(-1, 0, 0);

      // 16x16 checkerboard
      new_stream(8'h01);
      add_image(mk_dimb(16), 1);
      run_stream(-1, 0, 0);

      // back-to-back 12 then 10 with bubbles and stray pix_last
      rand_last = 1'b1;
      new_stream(8'($urandom));
      add_image(mk_dimb(12), 2);
      add_image(mk_dimb(10), 2);
      run_stream(-1, 0, 30);
      rand_last = 1'b0;

      // threshold edge
      new_stream(8'h40);
      add_image(mk_dimb(10), 3);
      run_stream(-1, 0, 10);

      // loader_run blocked by conv_busy, then accepted
      conv_busy = 1'b1;
      @(posedge clk); #1 loader_run = 1'b1;
      @(posedge clk); #1 loader_run = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("blocked_busy",  {31'd0, loader_busy}, 32'd0);
      check("blocked_ready", {31'd0, pix_ready}, 32'd0);
      conv_busy = 1'b0;
      new_stream(8'($urandom));
      add_image(mk_dimb(16), 2);
      run_stream(-1, 0, 20);

      // reset mid-row of the second image: image1 (11 words) + header2 + row0 of image2
      new_stream(8'($urandom));
      add_image(mk_dimb(10), 2);
      add_image(mk_dimb(10), 2);
      run_stream(13, 117, 0);

      // fresh run after reset starts at address 0
      new_stream(8'($urandom));
      add_image(mk_dimb(12), 2);
      run_stream(-1, 0, 15);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
